serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_bit.sv | 19 +
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg -- controller state type and default width       rev 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_bit.sv
// ============================================================================
// serial_add_bit -- combinational one-bit full adder cell         rev 1.0
// ============================================================================
`default_nettype none

module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl -- bit-serial adder controller, LSB first, one FA cell
// Optional subtract mode with SERIAL_ADD_SUB_EN.                  rev 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cell_b, cell_s, cell_co;

`ifdef SERIAL_ADD_SUB_EN
  logic               sub_q, sub_d;
  assign cell_b = b_q[0] ^ sub_q;
`else
  assign cell_b = b_q[0];
`endif

  serial_add_bit u_bit (
    .a    (a_q[0]),
    .b    (cell_b),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
          // Two's-complement subtract: invert B in the cell and seed carry with 1.
          sub_d   = sub;
          carry_d = sub | cin;
`else
          carry_d = cin;
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        carry_d = cell_co;
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl -- scoreboard bench for serial_add_ctrl, WIDTH=8
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1);
  end

  // Present one operand pair for a single edge; optionally push its expected result.
  task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic ts, input bit track);
    logic [8:0] e;
    a   = ta;
    b   = tb_v;
    cin = tc;
`ifdef SERIAL_ADD_SUB_EN
    sub = ts;
`endif
    if (ts) e = {1'b0, ta} + {1'b0, ~tb_v} + 9'd1;
    else    e = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
    if (track) exp_q.push_back(e);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; -1 if it never arrives.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (sum !== 8'h00) begin n_errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [7:0] va[3] = '{8'h00, 8'hFF, 8'hA5};
    logic [7:0] vb[3] = '{8'h00, 8'h01, 8'h5A};
    logic       vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] e;
    int cyc;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL add%0d_ready got=%b exp=1", k, in_ready); end
      drive_op(va[k], vb[k], vc[k], 1'b0, 1'b1);
      wait_valid(cyc);
      n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL add%0d_latency got=%0d exp=8", k, cyc); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_checks++; if (sum !== e[7:0]) begin n_errors++; $display("FAIL add%0d_sum got=%h exp=%h", k, sum, e[7:0]); end
      n_checks++; if (cout !== e[8]) begin n_errors++; $display("FAIL add%0d_cout got=%b exp=%b", k, cout, e[8]); end
      consume();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++; $display("FAIL add%0d_release got=%b/%b exp=0/1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    int cyc;
    drive_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL bp_latency got=%0d exp=8", cyc); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    for (int k = 0; k < 5; k++) begin
      a = 8'hC0 + 8'(k);
      b = 8'h0F;
      in_valid = k[0];
      n_checks++; if (sum !== e[7:0] || cout !== e[8]) begin
        n_errors++; $display("FAIL bp_hold%0d got=%b_%h exp=%b_%h", k, cout, sum, e[8], e[7:0]);
      end
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_errors++; $display("FAIL bp_flags%0d got=%b/%b exp=1/0", k, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (sum !== 8'h46 || cout !== 1'b0) begin n_errors++; $display("FAIL bp_final got=%b_%h exp=0_46", cout, sum); end
    consume();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release got=%b/%b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] e;
    int cyc;
    drive_op(8'h55, 8'h11, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL mrst_flags got=%b/%b exp=1/0", in_ready, out_valid);
    end
    n_checks++; if (sum !== 8'h00 || cout !== 1'b0) begin n_errors++; $display("FAIL mrst_sum got=%b_%h exp=0_00", cout, sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL mrst_latency got=%0d exp=8", cyc); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    n_checks++; if (sum !== e[7:0] || cout !== e[8]) begin
      n_errors++; $display("FAIL mrst_result got=%b_%h exp=%b_%h", cout, sum, e[8], e[7:0]);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[3] = '{8'h10, 8'h80, 8'h7F};
    logic [7:0] vb[3] = '{8'h22, 8'h80, 8'h01};
    logic       vc[3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] e;
    logic rdy_before;
    int sent = 0, got = 0, cyc = 0, last = 0;
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0];
    in_valid = 1'b1;
    for (int i = 0; i < 60 && got < 3; i++) begin
      rdy_before = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy_before && in_valid) begin
        exp_q.push_back({1'b0, va[sent]} + {1'b0, vb[sent]} + {8'd0, vc[sent]});
        sent++;
        if (sent < 3) begin a = va[sent]; b = vb[sent]; cin = vc[sent]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        n_checks++; if (sum !== e[7:0] || cout !== e[8]) begin
          n_errors++; $display("FAIL b2b_result%0d got=%b_%h exp=%b_%h", got, cout, sum, e[8], e[7:0]);
        end
        if (got > 0) begin
          n_checks++; if (cyc - last !== 10) begin n_errors++; $display("FAIL b2b_spacing%0d got=%0d exp=10", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    n_checks++; if (got !== 3) begin n_errors++; $display("FAIL b2b_count got=%0d exp=3", got); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [7:0] va[2] = '{8'h05, 8'h07};
    logic [7:0] vb[2] = '{8'h07, 8'h05};
    logic       vc[2] = '{1'b0, 1'b1};
    logic [8:0] e;
    int cyc;
    for (int k = 0; k < 2; k++) begin
      drive_op(va[k], vb[k], vc[k], 1'b1, 1'b1);
      wait_valid(cyc);
      n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL sub%0d_latency got=%0d exp=8", k, cyc); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_checks++; if (sum !== e[7:0] || cout !== e[8]) begin
        n_errors++; $display("FAIL sub%0d_result got=%b_%h exp=%b_%h", k, cout, sum, e[8], e[7:0]);
      end
      consume();
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
